alu_control_pipe: RTL and testbench

ALU_CONTROL_PIPE -- requirements
Module: alu_control_pipe

---
 rtl/alu_ctrl_pkg.sv | 65 ++++++
 rtl/alu_decode_comb.sv | 48 ++++
 rtl/alu_control_pipe.sv | 117 +++++++++++
 tb/tb_alu_control_pipe.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU control pipe.
// Contents: ALUControl encodings, ALUOp classes, Funct codes, FSM state
// constants and the held decode payload.
package alu_ctrl_pkg;

   localparam int unsigned ALU_W   = 4;
   localparam int unsigned OP_W    = 2;
   localparam int unsigned FUNCT_W = 6;
   localparam int unsigned CNT_W   = 8;

   typedef logic [ALU_W-1:0]   alu_ctrl_t;
   typedef logic [OP_W-1:0]    alu_op_t;
   typedef logic [FUNCT_W-1:0] funct_t;

   // ALUControl encodings
   localparam alu_ctrl_t ALU_AND  = 4'b0000;
   localparam alu_ctrl_t ALU_OR   = 4'b0001;
   localparam alu_ctrl_t ALU_ADD  = 4'b0010;
   localparam alu_ctrl_t ALU_XOR  = 4'b0011;
   localparam alu_ctrl_t ALU_SUB  = 4'b0110;
   localparam alu_ctrl_t ALU_SLT  = 4'b0111;
   localparam alu_ctrl_t ALU_SLL  = 4'b1000;
   localparam alu_ctrl_t ALU_SRL  = 4'b1001;
   localparam alu_ctrl_t ALU_SRA  = 4'b1010;
   localparam alu_ctrl_t ALU_NOR  = 4'b1100;
   localparam alu_ctrl_t ALU_MULT = 4'b1101;
   localparam alu_ctrl_t ALU_DIV  = 4'b1110;
   localparam alu_ctrl_t ALU_SLTU = 4'b1111;

   // Main-decoder op classes
   localparam alu_op_t OP_ADD   = 2'b00;
   localparam alu_op_t OP_SUB   = 2'b01;
   localparam alu_op_t OP_RTYPE = 2'b10;
   localparam alu_op_t OP_SLT   = 2'b11;

   // R-type function codes
   localparam funct_t F_ADD  = 6'b100000;
   localparam funct_t F_ADDU = 6'b100001;
   localparam funct_t F_SUB  = 6'b100010;
   localparam funct_t F_SUBU = 6'b100011;
   localparam funct_t F_AND  = 6'b100100;
   localparam funct_t F_OR   = 6'b100101;
   localparam funct_t F_XOR  = 6'b100110;
   localparam funct_t F_NOR  = 6'b100111;
   localparam funct_t F_SLT  = 6'b101010;
   localparam funct_t F_SLTU = 6'b101011;
   localparam funct_t F_SLL  = 6'b000000;
   localparam funct_t F_SRL  = 6'b000010;
   localparam funct_t F_SRA  = 6'b000011;
   localparam funct_t F_MULT = 6'b011000;
   localparam funct_t F_DIV  = 6'b011010;

   // FSM states
   typedef logic [0:0] state_t;
   localparam state_t ST_IDLE    = 1'b0;
   localparam state_t ST_MD_BUSY = 1'b1;

   // Decode result held in the output register
   typedef struct packed {
      alu_ctrl_t ctrl;
      logic      illegal;
      logic      is_md;
   } dec_t;

endpackage

// File: rtl/alu_decode_comb.sv
// Combinational ALU control decode.
// Ports: i_alu_op, i_funct -> o_alu_ctrl, o_illegal, o_is_md.
module alu_decode_comb
   import alu_ctrl_pkg::*;
(
   input  logic [OP_W-1:0]    i_alu_op,
   input  logic [FUNCT_W-1:0] i_funct,
   output logic [ALU_W-1:0]   o_alu_ctrl,
   output logic               o_illegal,
   output logic               o_is_md
);

   always_comb begin
      o_alu_ctrl = ALU_AND;
      o_illegal  = 1'b0;
      o_is_md    = 1'b0;
      case (i_alu_op)
         OP_ADD: o_alu_ctrl = ALU_ADD;
         OP_SUB: o_alu_ctrl = ALU_SUB;
         OP_SLT: o_alu_ctrl = ALU_SLT;
         default: begin
            case (i_funct)
               F_ADD, F_ADDU: o_alu_ctrl = ALU_ADD;
               F_SUB, F_SUBU: o_alu_ctrl = ALU_SUB;
               F_AND:  o_alu_ctrl = ALU_AND;
               F_OR:   o_alu_ctrl = ALU_OR;
               F_XOR:  o_alu_ctrl = ALU_XOR;
               F_NOR:  o_alu_ctrl = ALU_NOR;
               F_SLT:  o_alu_ctrl = ALU_SLT;
               F_SLTU: o_alu_ctrl = ALU_SLTU;
               F_SLL:  o_alu_ctrl = ALU_SLL;
               F_SRL:  o_alu_ctrl = ALU_SRL;
               F_SRA:  o_alu_ctrl = ALU_SRA;
               F_MULT: begin
                  o_alu_ctrl = ALU_MULT;
                  o_is_md    = 1'b1;
               end
               F_DIV: begin
                  o_alu_ctrl = ALU_DIV;
                  o_is_md    = 1'b1;
               end
               default: o_illegal = 1'b1;
            endcase
         end
      endcase
   end

endmodule

// File: rtl/alu_control_pipe.sv
// Registered ALU control stage with valid/ready handshake and a busy
// tracker for the multi-cycle mult/div unit.
// Ports: clk, reset_n; InValid/InReady/ALUOp/Funct request side;
// OutValid/OutReady/ALUControl/Illegal result side; Flush;
// MDStart pulse and MDBusy status for the mult/div unit.
module alu_control_pipe
   import alu_ctrl_pkg::*;
#(
   parameter int unsigned CTRL_W    = 4,
   parameter int unsigned MD_CYCLES = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              InValid,
   output logic              InReady,
   input  logic [1:0]        ALUOp,
   input  logic [5:0]        Funct,
   input  logic              Flush,
   output logic              OutValid,
   input  logic              OutReady,
   output logic [CTRL_W-1:0] ALUControl,
   output logic              Illegal,
   output logic              MDStart,
   output logic              MDBusy
);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CTRL_W-1:0] r_unused_pad;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             r_out_valid;
   dec_t             r_out;
   dec_t             w_dec;
   logic             w_accept;
   logic             w_hs;
   logic             w_md_start;
   logic             w_in_ready;

   alu_decode_comb u_dec (
      .i_alu_op   (ALUOp),
      .i_funct    (Funct),
      .o_alu_ctrl (w_dec.ctrl),
      .o_illegal  (w_dec.illegal),
      .o_is_md    (w_dec.is_md)
   );

   // A held mult/div result must hand off before anything new enters, so the
   // busy window can start cleanly; reset also blocks requests.
   assign w_in_ready = reset_n & (r_state == ST_IDLE)
                     & (~r_out_valid | (OutReady & ~r_out.is_md)) & ~Flush;
   assign w_accept   = InValid & w_in_ready;
   assign w_hs       = r_out_valid & OutReady;
   assign w_md_start = reset_n & w_hs & r_out.is_md & ~Flush & (r_state == ST_IDLE);

   // FSM state register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Next-state logic; counter runs MD_CYCLES-1 down to 0
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         ST_IDLE: begin
            if (w_md_start) begin
               w_state_nxt = ST_MD_BUSY;
               w_cnt_nxt   = CNT_W'(MD_CYCLES - 1);
            end
         end
         default: begin
            if (r_cnt == '0) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end
         end
      endcase
      if (Flush) begin
         w_state_nxt = ST_IDLE;
         w_cnt_nxt   = '0;
      end
   end

   // Output register: load on accept, drop on handshake, clear on flush
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_out_valid <= 1'b0;
         r_out       <= '0;
      end else if (Flush) begin
         r_out_valid <= 1'b0;
      end else if (w_accept) begin
         r_out_valid <= 1'b1;
         r_out       <= w_dec;
      end else if (w_hs) begin
         r_out_valid <= 1'b0;
      end
   end

   // Zero constant kept as a register-free tie for zero-extension clarity
   always_comb r_unused_pad = '0;

   assign InReady    = w_in_ready;
   assign OutValid   = r_out_valid;
   assign ALUControl = r_unused_pad | CTRL_W'(r_out.ctrl);
   assign Illegal    = r_out.illegal;
   assign MDStart    = w_md_start;
   assign MDBusy     = (r_state == ST_MD_BUSY);

endmodule

// File: tb/tb_alu_control_pipe.sv
// Randomized and directed bench for alu_control_pipe with a cycle-level
// reference model (table-driven decode, remaining-busy-cycles counter).
module tb_alu_control_pipe;

   localparam int unsigned MDC = 4;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       InValid;
   logic       InReady;
   logic [1:0] ALUOp;
   logic [5:0] Funct;
   logic       Flush;
   logic       OutValid;
   logic       OutReady;
   logic [3:0] ALUControl;
   logic       Illegal;
   logic       MDStart;
   logic       MDBusy;

   always #5 clk = ~clk;

   alu_control_pipe #(.CTRL_W(4), .MD_CYCLES(MDC)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .InValid    (InValid),
      .InReady    (InReady),
      .ALUOp      (ALUOp),
      .Funct      (Funct),
      .Flush      (Flush),
      .OutValid   (OutValid),
      .OutReady   (OutReady),
      .ALUControl (ALUControl),
      .Illegal    (Illegal),
      .MDStart    (MDStart),
      .MDBusy     (MDBusy)
   );

   int n_chk = 0;
   int n_err = 0;

   // reference model state
   bit       m_valid;
   bit       m_md;
   bit       m_ill;
   bit [3:0] m_ctrl;
   int       m_busy;   // remaining busy cycles, 0 = idle
   int       f_map[64];
   int       legal[15] = '{32, 33, 34, 35, 36, 37, 38, 39, 42, 43, 0, 2, 3, 24, 26};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic void ref_dec(input logic [1:0] op, input logic [5:0] f,
                                   output bit [3:0] c, output bit ill, output bit md);
      ill = 1'b0;
      md  = 1'b0;
      c   = 4'd0;
      if (op == 2'b00)      c = 4'b0010;
      else if (op == 2'b01) c = 4'b0110;
      else if (op == 2'b11) c = 4'b0111;
      else if (f_map[f] < 0) ill = 1'b1;
      else begin
         c  = 4'(f_map[f]);
         md = (f == 6'd24) || (f == 6'd26);
      end
   endfunction

   // drive one cycle of inputs, check outputs, then advance the model
   task automatic step(input bit v, input logic [1:0] op, input logic [5:0] f,
                       input bit fl, input bit ordy);
      bit exp_rdy, exp_start, acc, hs;
      @(negedge clk);
      InValid = v; ALUOp = op; Funct = f; Flush = fl; OutReady = ordy;
      #1;
      exp_rdy   = (m_busy == 0) && (!m_valid || (ordy && !m_md)) && !fl;
      exp_start = m_valid && ordy && m_md && !fl;
      chk("in_ready", 32'(InReady), 32'(exp_rdy));
      chk("md_start", 32'(MDStart), 32'(exp_start));
      chk("md_busy", 32'(MDBusy), 32'(m_busy > 0));
      chk("out_valid", 32'(OutValid), 32'(m_valid));
      if (m_valid) begin
         chk("alu_ctrl", 32'(ALUControl), 32'(m_ctrl));
         chk("illegal", 32'(Illegal), 32'(m_ill));
      end
      acc = v && exp_rdy;
      hs  = m_valid && ordy;
      if (fl) begin
         m_valid = 1'b0;
         m_busy  = 0;
      end else begin
         if (m_busy > 0) m_busy--;
         if (exp_start) m_busy = MDC;
         if (acc) begin
            ref_dec(op, f, m_ctrl, m_ill, m_md);
            m_valid = 1'b1;
         end else if (hs) begin
            m_valid = 1'b0;
         end
      end
   endtask

   // asynchronous reset pulse away from clock edges
   task automatic do_reset();
      @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk("rst_out_valid", 32'(OutValid), 32'd0);
      chk("rst_alu_ctrl", 32'(ALUControl), 32'd0);
      chk("rst_illegal", 32'(Illegal), 32'd0);
      chk("rst_md_busy", 32'(MDBusy), 32'd0);
      chk("rst_in_ready", 32'(InReady), 32'd0);
      chk("rst_md_start", 32'(MDStart), 32'd0);
      m_valid = 1'b0; m_md = 1'b0; m_ill = 1'b0; m_ctrl = '0; m_busy = 0;
      @(negedge clk);
      InValid = 1'b0; Flush = 1'b0; OutReady = 1'b1;
      reset_n = 1'b1;
      #1 chk("post_rst_in_ready", 32'(InReady), 32'd1);
   endtask

   initial begin
      foreach (f_map[i]) f_map[i] = -1;
      f_map[32] = 2;  f_map[33] = 2;  f_map[34] = 6;  f_map[35] = 6;
      f_map[36] = 0;  f_map[37] = 1;  f_map[38] = 3;  f_map[39] = 12;
      f_map[42] = 7;  f_map[43] = 15; f_map[0]  = 8;  f_map[2]  = 9;
      f_map[3]  = 10; f_map[24] = 13; f_map[26] = 14;
      reset_n = 1'b0; InValid = 1'b0; ALUOp = '0; Funct = '0; Flush = 1'b0; OutReady = 1'b0;
      m_valid = 1'b0; m_md = 1'b0; m_ill = 1'b0; m_ctrl = '0; m_busy = 0;
      #1;
      chk("init_out_valid", 32'(OutValid), 32'd0);
      chk("init_in_ready", 32'(InReady), 32'd0);
      do_reset();

      // nor decode
      step(1, 2'b10, 6'b100111, 0, 1);
      step(0, 2'b00, 6'd0, 0, 1);
      chk("nor_ctrl", 32'(ALUControl), 32'hC);

      // streaming add, sub, and, or, slt
      step(1, 2'b00, 6'd0, 0, 1);
      step(1, 2'b01, 6'd0, 0, 1);
      step(1, 2'b10, 6'b100100, 0, 1);
      step(1, 2'b10, 6'b100101, 0, 1);
      step(1, 2'b11, 6'd0, 0, 1);
      chk("stream_or", 32'(ALUControl), 32'h1);
      step(0, 2'b00, 6'd0, 0, 1);
      chk("stream_slt", 32'(ALUControl), 32'h7);

      // mult busy window
      step(1, 2'b10, 6'b011000, 0, 1);
      step(1, 2'b00, 6'd0, 0, 1);
      chk("mult_start", 32'(MDStart), 32'd1);
      for (int i = 0; i < int'(MDC); i++) begin
         step(1, 2'b00, 6'd0, 0, 1);
         chk("mult_busy", 32'(MDBusy), 32'd1);
      end
      step(1, 2'b00, 6'd0, 0, 1);
      chk("mult_resume", 32'(InReady), 32'd1);

      // hold xor under backpressure
      step(1, 2'b10, 6'b100110, 0, 1);
      for (int i = 0; i < 3; i++) begin
         step(1, 2'b00, 6'd0, 0, 0);
         chk("xor_hold", 32'(ALUControl), 32'h3);
      end
      step(0, 2'b00, 6'd0, 0, 1);

      // illegal funct
      step(1, 2'b10, 6'b111111, 0, 1);
      step(0, 2'b00, 6'd0, 0, 1);
      chk("illegal_flag", 32'(Illegal), 32'd1);
      step(0, 2'b00, 6'd0, 0, 1);
      chk("illegal_no_busy", 32'(MDBusy), 32'd0);

      // div then flush in second busy cycle
      step(1, 2'b10, 6'b011010, 0, 1);
      step(0, 2'b00, 6'd0, 0, 1);
      step(0, 2'b00, 6'd0, 0, 1);
      step(0, 2'b00, 6'd0, 1, 1);
      step(0, 2'b00, 6'd0, 0, 1);
      chk("flush_busy", 32'(MDBusy), 32'd0);

      // div then reset mid-busy
      step(1, 2'b10, 6'b011010, 0, 1);
      step(0, 2'b00, 6'd0, 0, 1);
      step(0, 2'b00, 6'd0, 0, 1);
      do_reset();

      // randomized traffic
      for (int i = 0; i < 1500; i++) begin
         bit v, fl, ordy;
         logic [1:0] op;
         logic [5:0] f;
         v    = ($urandom_range(0, 3) != 0);
         fl   = ($urandom_range(0, 19) == 0);
         ordy = ($urandom_range(0, 9) < 7);
         op   = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'($urandom_range(0, 3));
         f    = ($urandom_range(0, 9) < 8) ? 6'(legal[$urandom_range(0, 14)])
                                           : 6'($urandom_range(0, 63));
         step(v, op, f, fl, ordy);
         if (i % 400 == 399) do_reset();
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
